// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x N word RAM: one asynchronous read port, one synchronous write port.
module dmem_array #(
   parameter int N     = 32,
   parameter int DEPTH = 256,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [N-1:0]  wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [N-1:0]  rdata_o
);

   logic [N-1:0] mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) mem[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-bus slave: req/ack handshake with programmable wait states in front of a
// word-addressed RAM; misaligned and out-of-range accesses are answered with err.
module dmem_responder #(
   parameter int N     = 32,
   parameter int DEPTH = 256,
   parameter int WAIT  = 2
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         req,
   input  logic         d_rw,
   input  logic [N-1:0] daddr,
   input  logic [N-1:0] ddata_w,
   output logic [N-1:0] ddata_r,
   output logic         ack,
   output logic         err
);
   import dmem_pkg::*;

   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] WAIT_L = 4'(WAIT);

   dmem_state_t   state_q;
   logic [3:0]    cnt_q;
   logic [AW-1:0] idx_q;
   logic [N-1:0]  wdata_q;
   logic          rw_q;
   logic          errc_q;
   logic          ack_q;
   logic          err_q;
   logic [N-1:0]  rdata_q;

   logic          in_err;
   logic          enter_resp;
   logic [AW-1:0] acc_idx;
   logic [N-1:0]  acc_wdata;
   logic          acc_rw;
   logic          acc_err;
   logic          ram_we;
   logic [N-1:0]  ram_rdata;

   // Power-of-2 depth: any set bit above the index field means out of range.
   assign in_err = (daddr[1:0] != 2'b00) | (daddr[N-1:AW+2] != '0);

   // With WAIT=0 the access happens on the capture edge, straight from the inputs.
   assign enter_resp = ((state_q == IDLE) && req && (WAIT == 0)) ||
                       ((state_q == dmem_pkg::WAIT) && (cnt_q == 4'd0));

   always_comb begin
      acc_idx   = idx_q;
      acc_wdata = wdata_q;
      acc_rw    = rw_q;
      acc_err   = errc_q;
      if (state_q == IDLE) begin
         acc_idx   = daddr[AW+1:2];
         acc_wdata = ddata_w;
         acc_rw    = d_rw;
         acc_err   = in_err;
      end
   end

   assign ram_we = enter_resp && (acc_rw == RW_WRITE) && !acc_err;

   dmem_array #(.N(N), .DEPTH(DEPTH)) u_array (
      .clk_i   (CLK),
      .we_i    (ram_we),
      .waddr_i (acc_idx),
      .wdata_i (acc_wdata),
      .raddr_i (acc_idx),
      .rdata_o (ram_rdata)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         wdata_q <= '0;
         rw_q    <= RW_READ;
         errc_q  <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req) begin
                  idx_q   <= daddr[AW+1:2];
                  wdata_q <= ddata_w;
                  rw_q    <= d_rw;
                  errc_q  <= in_err;
                  cnt_q   <= WAIT_L;
                  state_q <= (WAIT == 0) ? RESP : dmem_pkg::WAIT;
               end
            end
            dmem_pkg::WAIT: begin
               if (cnt_q == 4'd0) state_q <= RESP;
               else               cnt_q   <= cnt_q - 4'd1;
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase

         ack_q <= enter_resp;
         err_q <= enter_resp && acc_err;
         // Read data is refreshed on every response and held until the next one.
         if (enter_resp)
            rdata_q <= (acc_err || (acc_rw == RW_WRITE)) ? '0 : ram_rdata;
      end
   end

   assign ack     = ack_q;
   assign err     = err_q;
   assign ddata_r = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench: WAIT=2 instance for latency/error/reset cases,
// WAIT=0 instance for back-to-back requests with req held high.
module tb_dmem_responder;

   localparam int W_A = 2;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;

   logic        req_a = 1'b0, rw_a = 1'b1;
   logic [31:0] addr_a = '0, wd_a = '0, rd_a;
   logic        ack_a, err_a;

   logic        req_b = 1'b0, rw_b = 1'b1;
   logic [31:0] addr_b = '0, wd_b = '0, rd_b;
   logic        ack_b, err_b;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem_a [int unsigned];
   logic [31:0] mem_b [4];

   always #5 CLK = ~CLK;

   dmem_responder #(.N(32), .DEPTH(256), .WAIT(W_A)) u_dut (
      .CLK(CLK), .RESET(RESET), .req(req_a), .d_rw(rw_a), .daddr(addr_a),
      .ddata_w(wd_a), .ddata_r(rd_a), .ack(ack_a), .err(err_a));

   dmem_responder #(.N(32), .DEPTH(256), .WAIT(0)) u_dut0 (
      .CLK(CLK), .RESET(RESET), .req(req_b), .d_rw(rw_b), .daddr(addr_b),
      .ddata_w(wd_b), .ddata_r(rd_b), .ack(ack_b), .err(err_b));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One complete transaction on the WAIT=2 instance, checked against the model.
   task automatic txn(input bit rw, input logic [31:0] a, input logic [31:0] d,
                      input bit drop, input string tag);
      int n;
      bit e;
      e = ((a % 4) != 0) || ((a / 4) >= 256);
      @(negedge CLK);
      rw_a = rw; addr_a = a; wd_a = d; req_a = 1'b1;
      @(posedge CLK); #1;
      if (drop) begin
         req_a = 1'b0; rw_a = ~rw; addr_a = $urandom; wd_a = $urandom;
      end
      n = 0;
      while (ack_a !== 1'b1 && n < 20) begin
         @(posedge CLK); #1; n++;
      end
      chk({tag, ".lat"}, n, W_A + 1);
      chk({tag, ".err"}, err_a, e);
      if (rw) begin
         if (e) chk({tag, ".rd0"}, rd_a, 0);
         else if (mem_a.exists(a / 4)) chk({tag, ".rd"}, rd_a, mem_a[a / 4]);
      end else if (!e && ack_a === 1'b1) begin
         mem_a[a / 4] = d;
      end
      @(posedge CLK); #1;
      chk({tag, ".ack1"}, ack_a, 0);
      req_a = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int n, acks, last, cyc, idx;
      logic [31:0] a, d;
      bit [3:0] b_rw;
      logic [31:0] b_addr [8];
      logic [31:0] b_data [8];

      repeat (2) @(posedge CLK);
      #1;
      chk("rst.ack", ack_a, 0);
      chk("rst.err", err_a, 0);
      chk("rst.rd",  rd_a, 0);
      chk("rst.ack0", ack_b, 0);
      @(negedge CLK) RESET = 1'b0;

      txn(1'b0, 32'h20, 32'h1234, 1'b0, "pre.wr20");
      txn(1'b0, 32'h10, 32'hDEADBEEF, 1'b0, "t2.wr");
      txn(1'b1, 32'h10, 32'h0, 1'b0, "t2.rd");
      txn(1'b0, 32'h12, 32'h1, 1'b0, "t3.mis");
      txn(1'b1, 32'h10, 32'h0, 1'b1, "t3.rd");
      txn(1'b1, 32'h400, 32'h0, 1'b0, "t4.oor");

      // Reset while the response is being presented clears outputs at once.
      @(negedge CLK);
      rw_a = 1'b1; addr_a = 32'h10; req_a = 1'b1;
      @(posedge CLK); #1;
      req_a = 1'b0;
      n = 0;
      while (ack_a !== 1'b1 && n < 20) begin
         @(posedge CLK); #1; n++;
      end
      chk("t1.ack", ack_a, 1);
      chk("t1.rdpre", rd_a, 32'hDEADBEEF);
      #2 RESET = 1'b1;
      #1;
      chk("t1.ack0", ack_a, 0);
      chk("t1.err0", err_a, 0);
      chk("t1.rd0",  rd_a, 0);
      @(negedge CLK) RESET = 1'b0;

      // Reset in the wait phase of a write: no ack, RAM untouched.
      @(negedge CLK);
      rw_a = 1'b0; addr_a = 32'h20; wd_a = 32'h55; req_a = 1'b1;
      @(posedge CLK); #1;
      req_a = 1'b0;
      @(posedge CLK); #2;
      RESET = 1'b1;
      #1 chk("t5.ack", ack_a, 0);
      @(negedge CLK) RESET = 1'b0;
      acks = 0;
      repeat (6) begin
         @(posedge CLK); #1;
         if (ack_a === 1'b1) acks++;
      end
      chk("t5.noack", acks, 0);
      txn(1'b1, 32'h20, 32'h0, 1'b0, "t5.rd");

      repeat (40) begin
         case ($urandom_range(0, 9))
            7:       a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
            8:       a = (32'd256 + 32'($urandom_range(0, 1000))) * 4;
            9:       a = $urandom | 32'h8000_0000;
            default: a = 32'($urandom_range(0, 15)) * 4;
         endcase
         d = $urandom;
         txn(1'($urandom_range(0, 1)), a, d, 1'($urandom_range(0, 1)), "rnd");
      end

      // WAIT=0: four writes then four reads with req held high throughout.
      for (int i = 0; i < 4; i++) begin
         b_rw[i] = 1'b0; b_addr[i] = 32'(i * 4); b_data[i] = $urandom;
         b_rw[i+4] = 1'b1; b_addr[i+4] = 32'(i * 4); b_data[i+4] = $urandom;
      end
      @(negedge CLK);
      idx = 0; cyc = 0; last = -1;
      rw_b = 1'b0; addr_b = b_addr[0]; wd_b = b_data[0]; req_b = 1'b1;
      while (idx < 8 && cyc < 40) begin
         @(posedge CLK); #1; cyc++;
         if (ack_b === 1'b1) begin
            if (last < 0) chk("t6.first", cyc, 1);
            else          chk("t6.gap", cyc - last, 2);
            last = cyc;
            chk("t6.err", err_b, 0);
            if (idx < 4) mem_b[idx] = b_data[idx];
            else         chk("t6.rd", rd_b, mem_b[idx - 4]);
            idx++;
            if (idx < 8) begin
               rw_b = (idx >= 4); addr_b = b_addr[idx]; wd_b = b_data[idx];
            end else begin
               req_b = 1'b0;
            end
         end
      end
      chk("t6.count", idx, 8);
      @(posedge CLK); #1;
      chk("t6.ackoff", ack_b, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
